// File: rtl/pc_lut_loader.sv
// Boot-time loader for the branch-target table: accepts a valid/ready target stream
// and writes it to consecutive table entries. Optional shadow copy: PC_LUT_LOADER_SHADOW_EN.
module pc_lut_loader #(
  parameter int D = 8,
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          wr_valid,
  input  logic [D-1:0]  wr_data,
  input  logic          wr_last,
  output logic          wr_ready,
  output logic          lut_we,
  output logic [IW-1:0] lut_idx,
  output logic [D-1:0]  lut_target,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [IW:0]   count,
  input  logic [IW-1:0] rd_idx,
  output logic [D-1:0]  rd_target
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q;
  logic          accept;
  logic          final_beat;
  logic          seq_start;

  // Ready depends on state only, so upstream may hold wr_valid without a comb loop.
  assign wr_ready   = (state_q == LOAD);
  assign busy       = (state_q == LOAD);
  assign done       = (state_q == DONE);
  assign accept     = wr_valid && (state_q == LOAD);
  assign final_beat = wr_last || (ptr_q == IW'(N - 1));
  assign seq_start  = start && (state_q != LOAD);

  // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (accept && final_beat) state_d = DONE;
      DONE:    if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state updates are non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      count      <= '0;
      err        <= 1'b0;
      lut_we     <= 1'b0;
      lut_idx    <= '0;
      lut_target <= '0;
    end else begin
      state_q <= state_d;
      lut_we  <= accept;
      if (accept) begin
        lut_idx    <= ptr_q;
        lut_target <= wr_data;
        ptr_q      <= ptr_q + 1'b1;
        count      <= count + 1'b1;
      end
      if (seq_start) begin
        ptr_q <= '0;
        count <= '0;
        err   <= 1'b0;
      end else if ((state_q == DONE) && wr_valid) begin
        err <= 1'b1;
      end
    end
  end

`ifdef PC_LUT_LOADER_SHADOW_EN
  logic [D-1:0] shadow_q [N];

  // NOTE: the shadow is reset explicitly because readback of unwritten entries must return 0;
  // this forces flops rather than RAM, which is acceptable at these sizes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) shadow_q[i] <= '0;
    end else if (accept) begin
      shadow_q[ptr_q] <= wr_data;
    end
  end

  assign rd_target = shadow_q[rd_idx];
`else
  logic unused_rd_idx;

  assign unused_rd_idx = ^rd_idx;
  assign rd_target     = '0;
`endif

endmodule

// File: tb/tb_pc_lut_loader.sv
// Self-checking bench for pc_lut_loader: directed scenarios plus randomized sequences,
// scoreboarded against a sequence-level reference model of the loader.
module tb_pc_lut_loader;

  localparam int D  = 8;
  localparam int N  = 8;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          wr_valid;
  logic [D-1:0]  wr_data;
  logic          wr_last;
  logic          wr_ready;
  logic          lut_we;
  logic [IW-1:0] lut_idx;
  logic [D-1:0]  lut_target;
  logic          busy;
  logic          done;
  logic          err;
  logic [IW:0]   count;
  logic [IW-1:0] rd_idx;
  logic [D-1:0]  rd_target;

  pc_lut_loader #(.D(D), .N(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .wr_ready   (wr_ready),
    .lut_we     (lut_we),
    .lut_idx    (lut_idx),
    .lut_target (lut_target),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .count      (count),
    .rd_idx     (rd_idx),
    .rd_target  (rd_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int tgt;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model: a sequence is either accepting, finished, or not yet started.
  bit  m_loading;
  bit  m_finished;
  bit  m_err;
  int  m_cnt;
  int  m_table [N];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every table write must match the oldest outstanding accepted beat.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && lut_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: idx %0d target %0d with nothing expected", lut_idx, lut_target);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("lut_idx", int'(lut_idx), e.idx);
        check("lut_target", int'(lut_target), e.tgt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_loading  = 0;
    m_finished = 0;
    m_err      = 0;
    m_cnt      = 0;
    for (int i = 0; i < N; i++) m_table[i] = 0;
  endtask

  task automatic step(input bit st, input bit v, input int d, input bit l);
    bit acc;
    start    = st;
    wr_valid = v;
    wr_data  = D'(d);
    wr_last  = l;
    check("wr_ready", int'(wr_ready), int'(m_loading));
    acc = 0;
    if (m_loading) begin
      if (v) begin
        acc = 1;
        exp_q.push_back('{idx: m_cnt, tgt: d & ((1 << D) - 1)});
        m_table[m_cnt] = d & ((1 << D) - 1);
        m_cnt++;
        if (l || m_cnt == N) begin
          m_loading  = 0;
          m_finished = 1;
        end
      end
    end else if (st) begin
      m_loading  = 1;
      m_finished = 0;
      m_cnt      = 0;
      m_err      = 0;
    end else if (m_finished && v) begin
      m_err = 1;
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    check("lut_we", int'(lut_we), int'(acc));
    check("busy", int'(busy), int'(m_loading));
    check("done", int'(done), int'(m_finished));
    check("count", int'(count), m_cnt);
    check("err", int'(err), int'(m_err));
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check("rst_lut_we", int'(lut_we), 0);
    check("rst_lut_idx", int'(lut_idx), 0);
    check("rst_lut_target", int'(lut_target), 0);
    check("rst_wr_ready", int'(wr_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_count", int'(count), 0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_shadow();
    for (int i = 0; i < N; i++) begin
      rd_idx = IW'(i);
      #1;
`ifdef PC_LUT_LOADER_SHADOW_EN
      check("rd_target", int'(rd_target), m_table[i]);
`else
      check("rd_target", int'(rd_target), 0);
`endif
    end
  endtask

  initial begin
    start    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    wr_last  = 1'b0;
    rd_idx   = '0;
    reset_n  = 1'b0;
    #2;
    apply_reset();

    // Full back-to-back load, wr_last on beat 8.
    step(1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) step(0, 1, 4 * i, i == 8);
    step(0, 0, 0, 0);
    check_shadow();

    // Short sequence after reset: unwritten entries read 0.
    apply_reset();
    step(1, 0, 0, 0);
    step(0, 1, 4, 0);
    step(0, 1, 8, 1);
    step(0, 0, 0, 0);
    check_shadow();

    // Pointer limit forces DONE; extra beat flags err; start clears it.
    step(1, 0, 0, 0);
    for (int i = 0; i < N; i++) step(0, 1, 100 + i, 0);
    step(0, 1, 99, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 55, 1);

    // Gapped valid: one beat every third cycle.
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 20 + i, i == 2);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
    end

    // Reset while the second write is on the table port: that write is dropped.
    step(1, 0, 0, 0);
    step(0, 1, 11, 0);
    step(0, 1, 22, 0);
    apply_reset();
    step(0, 1, 33, 0);
    step(0, 1, 44, 1);
    check_shadow();

    // Start during LOAD is ignored, including alongside the final beat.
    step(1, 0, 0, 0);
    step(0, 1, 7, 0);
    step(1, 1, 9, 0);
    step(1, 0, 0, 0);
    step(1, 1, 13, 1);
    step(0, 0, 0, 0);

    // Randomized sequences with gaps, early last, stray start and post-DONE valid.
    for (int s = 0; s < 12; s++) begin
      step(1, 0, 0, 0);
      for (int c = 0; c < N + 6; c++) begin
        bit v;
        v = ($urandom_range(0, 3) != 0);
        step($urandom_range(0, 9) == 0, v, int'($urandom_range(0, 255)),
             v && ($urandom_range(0, 7) == 0));
      end
      check_shadow();
    end

    step(0, 0, 0, 0);
    check("pending_writes", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
